fir_block_serializer: RTL and testbench
=======================================

Name: fir_block_serializer

Overview:
- Output-side converter for the 3-path parallel FIR: does the reverse of the input sample distributor.
- Accepts one block of NUM_PARALLEL_PATHS wide accumulator results per handshake and emits them one sample per cycle, in time order, on a serial valid/ready stream.
- Each lane is requantized from ACCUM_WIDTH to OUT_WIDTH on the way out.
- Sits between the path-combine stage and the downstream DAC/packetizer interface.

Parameters:
- NUM_PARALLEL_PATHS, 3: lanes per input block.
- ACCUM_WIDTH, 35: signed width of each input lane.
- OUT_WIDTH, 16: signed width of each output sample.
- FRAC_SHIFT, 15: LSBs dropped during requantization; FRAC_SHIFT >= 1 and FRAC_SHIFT+OUT_WIDTH <= ACCUM_WIDTH.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  input block valid.
- in_ready  out  1  block accepted when in_valid && in_ready.
- in_data  in  NUM_PARALLEL_PATHS*ACCUM_WIDTH  signed lanes; lane 0 in the LSBs and earliest in time.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts when out_valid && out_ready.
- out_data  out  OUT_WIDTH  signed requantized sample.
- out_last  out  1  high with the final lane (index NUM_PARALLEL_PATHS-1) of a block.

Behaviour:
- Reset values (asynchronous): state=IDLE, lane_idx=0, block register=0, out_valid=0, out_data=0, out_last=0. Reset mid-block discards the partial block with no further output.
- FSM states:
  - IDLE: in_ready=1. On accept, latch in_data, set lane_idx=0, go to SHIFT.
  - SHIFT: out_valid=1. out_data=requant(lane[lane_idx]). out_last=(lane_idx==NUM_PARALLEL_PATHS-1).
- SHIFT advance rules:
  - On an out handshake with lane_idx<N-1: lane_idx++.
  - On an out handshake with lane_idx==N-1: if in_valid, latch the new block and set lane_idx=0 (stay in SHIFT, no bubble); otherwise go to IDLE.
- in_ready in SHIFT equals (lane_idx==N-1 && out_ready). It is combinational from out_ready, so there is no skid buffer.
- Latency: the first sample of a block is valid the cycle after block acceptance (output registered). Sustained throughput is 1 sample/clk; in_ready pulses once per N cycles.
- Stall: while out_valid && !out_ready, out_data, out_last and lane_idx hold stable.
- in_data is ignored unless accepted. in_valid may drop at any time without effect.
- Base requant (truncate/wrap): out = lane[FRAC_SHIFT+OUT_WIDTH-1:FRAC_SHIFT]. This is floor toward -inf; overflow wraps.

Optional Feature:
- Macro FIR_SER_ROUND_SAT_EN.
- Defined:
  - Round half-up: add 2^(FRAC_SHIFT-1) in ACCUM_WIDTH+1 signed arithmetic, then arithmetic shift right by FRAC_SHIFT.
  - Saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - Add output port sat_flag (1 bit): registered, high alongside any output sample that was clipped. Reset 0.
- Undefined: base truncate/wrap only, and no sat_flag port.

Decomposition:
- Shared package fir_pkg:
  - Widths: INPUT/COEFF/ACCUM/OUT_WIDTH, FRAC_SHIFT, NUM_PARALLEL_PATHS.
  - lane_idx_t = logic [$clog2(NUM_PARALLEL_PATHS)-1:0].
  - Signed accumulator and sample typedefs.
  - FSM state enum {IDLE, SHIFT}.
- One combinational sub-module fir_requant: ACCUM_WIDTH in, OUT_WIDTH out, sat out. Round/sat logic is selected by the macro inside it; it is reusable by other filter outputs.

Test Plan:
- Reset, then one block {lane0=3<<15, lane1=-(1<<15), lane2=0} with out_ready=1 -> outputs 3, -1, 0 on consecutive cycles starting 1 cycle after accept; out_last only on 0; then IDLE with in_ready=1.
- in_valid held high, 4 back-to-back blocks, out_ready=1 -> 12 contiguous output cycles with no bubble; in_ready high exactly on cycles 0,3,6,9 relative to the first accept.
- Lane = (5<<15)+(1<<14) and lane = -(1<<14):
  - Macro off -> 5, -1.
  - Macro on -> 6, 0; sat_flag=0.
- Lane = 2^31 and lane = -2^31:
  - Macro off -> 0, 0 (wrap).
  - Macro on -> 32767, -32768 with sat_flag=1 on both.
- out_ready toggled 1,0,0,1,0,1 during a block -> each sample held stable while stalled; lane order 0,1,2 preserved; no new block accepted until the lane-2 handshake.
- reset asserted after lane 0 handshake -> out_valid drops asynchronously; after release, state=IDLE, in_ready=1, and the remaining lanes are never emitted.

Source files
------------

// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared widths, types and FSM states for the parallel FIR datapath
package fir_pkg;

    localparam int INPUT_WIDTH        = 16;
    localparam int COEFF_WIDTH        = 16;
    localparam int ACCUM_WIDTH        = 35;
    localparam int OUT_WIDTH          = 16;
    localparam int FRAC_SHIFT         = 15;
    localparam int NUM_PARALLEL_PATHS = 3;

    typedef logic [$clog2(NUM_PARALLEL_PATHS)-1:0] lane_idx_t;
    typedef logic signed [ACCUM_WIDTH-1:0]          accum_t;
    typedef logic signed [OUT_WIDTH-1:0]            sample_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/fir_requant.sv
// rtl/fir_requant.sv - accumulator to sample requantizer; FIR_SER_ROUND_SAT_EN selects round/saturate over truncate/wrap
module fir_requant #(
    parameter int ACCUM_WIDTH = fir_pkg::ACCUM_WIDTH,
    parameter int OUT_WIDTH   = fir_pkg::OUT_WIDTH,
    parameter int FRAC_SHIFT  = fir_pkg::FRAC_SHIFT
) (
    input  logic [ACCUM_WIDTH-1:0] acc_in,
    output logic [OUT_WIDTH-1:0]   sample_out,
    output logic                   sat_out
);

`ifdef FIR_SER_ROUND_SAT_EN
    localparam int SW = ACCUM_WIDTH + 1;
    localparam logic signed [SW-1:0] HALF    = SW'(1) << (FRAC_SHIFT - 1);
    localparam logic signed [SW-1:0] SAT_MAX = (SW'(1) << (OUT_WIDTH - 1)) - SW'(1);
    localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;

    logic signed [SW-1:0] rnd_sum;
    logic signed [SW-1:0] rnd_shr;

    // One guard bit keeps the half-LSB add from overflowing at the positive extreme.
    always_comb begin
        rnd_sum    = $signed({acc_in[ACCUM_WIDTH-1], acc_in}) + HALF;
        rnd_shr    = rnd_sum >>> FRAC_SHIFT;
        sample_out = rnd_shr[OUT_WIDTH-1:0];
        sat_out    = 1'b0;
        if (rnd_shr > SAT_MAX) begin
            sample_out = SAT_MAX[OUT_WIDTH-1:0];
            sat_out    = 1'b1;
        end else if (rnd_shr < SAT_MIN) begin
            sample_out = SAT_MIN[OUT_WIDTH-1:0];
            sat_out    = 1'b1;
        end
    end
`else
    logic unused_low;

    assign sample_out = acc_in[FRAC_SHIFT+OUT_WIDTH-1:FRAC_SHIFT];
    assign sat_out    = 1'b0;
    assign unused_low = ^acc_in[FRAC_SHIFT-1:0];

    // Guard bits above the output field are simply discarded (wrap).
    generate
        if (ACCUM_WIDTH > FRAC_SHIFT + OUT_WIDTH) begin : g_high
            logic unused_high;
            assign unused_high = ^acc_in[ACCUM_WIDTH-1:FRAC_SHIFT+OUT_WIDTH];
        end
    endgenerate
`endif

endmodule

// File: rtl/fir_block_serializer.sv
// rtl/fir_block_serializer.sv - parallel accumulator block to serial requantized sample stream; FIR_SER_ROUND_SAT_EN adds round/sat and sat_flag
module fir_block_serializer #(
    parameter int NUM_PARALLEL_PATHS = fir_pkg::NUM_PARALLEL_PATHS,
    parameter int ACCUM_WIDTH        = fir_pkg::ACCUM_WIDTH,
    parameter int OUT_WIDTH          = fir_pkg::OUT_WIDTH,
    parameter int FRAC_SHIFT         = fir_pkg::FRAC_SHIFT
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic [NUM_PARALLEL_PATHS*ACCUM_WIDTH-1:0] in_data,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [OUT_WIDTH-1:0]                      out_data,
    output logic                                      out_last
`ifdef FIR_SER_ROUND_SAT_EN
    ,
    output logic                                      sat_flag
`endif
);

    import fir_pkg::*;

    localparam int BW = NUM_PARALLEL_PATHS * ACCUM_WIDTH;
    localparam int LW = (NUM_PARALLEL_PATHS > 1) ? $clog2(NUM_PARALLEL_PATHS) : 1;

    typedef logic [LW-1:0] lane_t;
    localparam lane_t LAST_LANE = lane_t'(NUM_PARALLEL_PATHS - 1);

    state_t                 state_q, state_d;
    lane_t                  lane_q, lane_d;
    logic [BW-1:0]          block_q, block_d;
    logic [OUT_WIDTH-1:0]   out_data_q, out_data_d;
    logic                   out_last_q, out_last_d;
    logic                   sat_q, sat_d;

    logic                   load;
    logic                   adv;
    logic                   drain;
    lane_t                  nxt_lane;
    logic [BW-1:0]          rq_src;
    logic [ACCUM_WIDTH-1:0] rq_in;
    logic [OUT_WIDTH-1:0]   rq_out;
    logic                   rq_sat;

    // Handshake decode; in_ready is combinational from out_ready on the last lane.
    always_comb begin
        in_ready = 1'b0;
        load     = 1'b0;
        adv      = 1'b0;
        drain    = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                load     = in_valid;
            end
            SHIFT: begin
                if (out_ready) begin
                    if (lane_q == LAST_LANE) begin
                        in_ready = 1'b1;
                        load     = in_valid;
                        drain    = !in_valid;
                    end else begin
                        adv = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // The lane that will be on the output next cycle is requantized now so out_data is a flop.
    assign nxt_lane = (load || lane_q == LAST_LANE) ? '0 : lane_q + lane_t'(1);
    assign rq_src   = load ? in_data : block_q;
    assign rq_in    = rq_src[nxt_lane*ACCUM_WIDTH +: ACCUM_WIDTH];

    fir_requant #(
        .ACCUM_WIDTH (ACCUM_WIDTH),
        .OUT_WIDTH   (OUT_WIDTH),
        .FRAC_SHIFT  (FRAC_SHIFT)
    ) u_requant (
        .acc_in     (rq_in),
        .sample_out (rq_out),
        .sat_out    (rq_sat)
    );

    always_comb begin
        state_d    = state_q;
        lane_d     = lane_q;
        block_d    = block_q;
        out_data_d = out_data_q;
        out_last_d = out_last_q;
        sat_d      = sat_q;
        if (load || adv) begin
            state_d    = SHIFT;
            lane_d     = nxt_lane;
            block_d    = rq_src;
            out_data_d = rq_out;
            out_last_d = (nxt_lane == LAST_LANE);
            sat_d      = rq_sat;
        end else if (drain) begin
            state_d    = IDLE;
            out_last_d = 1'b0;
            sat_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            lane_q     <= '0;
            block_q    <= '0;
            out_data_q <= '0;
            out_last_q <= 1'b0;
            sat_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            lane_q     <= lane_d;
            block_q    <= block_d;
            out_data_q <= out_data_d;
            out_last_q <= out_last_d;
            sat_q      <= sat_d;
        end
    end

    assign out_valid = (state_q == SHIFT);
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

`ifdef FIR_SER_ROUND_SAT_EN
    assign sat_flag = sat_q;
`else
    logic unused_sat;
    assign unused_sat = sat_q;
`endif

endmodule

// File: tb/tb_fir_block_serializer.sv
// tb/tb_fir_block_serializer.sv - directed self-checking bench for fir_block_serializer
module tb_fir_block_serializer;

    localparam int N  = 3;
    localparam int AW = 35;
    localparam int OW = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [N*AW-1:0] in_data;
    logic            out_valid;
    logic            out_ready;
    logic [OW-1:0]   out_data;
    logic            out_last;
`ifdef FIR_SER_ROUND_SAT_EN
    logic            sat_flag;
`endif

    int errors = 0;
    int checks = 0;

    fir_block_serializer dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
`ifdef FIR_SER_ROUND_SAT_EN
        ,
        .sat_flag  (sat_flag)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N*AW-1:0] mk_blk(input longint l0, input longint l1, input longint l2);
        return {AW'(l2), AW'(l1), AW'(l0)};
    endfunction

    // Caller sits just after an edge with the DUT idle; block is offered, drained with out_ready=1.
    task automatic run_block(input string tag, input logic [N*AW-1:0] blk,
                             input int e0, input int e1, input int e2, input logic [2:0] es);
        int exp_d [3];
        exp_d = '{e0, e1, e2};
        in_valid  = 1'b1;
        in_data   = blk;
        out_ready = 1'b1;
        #1;
        check({tag, "_in_ready"}, in_ready, 1);
        step();
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom, $urandom, $urandom};
        for (int j = 0; j < N; j++) begin
            #1;
            check($sformatf("%s_valid%0d", tag, j), out_valid, 1);
            check($sformatf("%s_data%0d", tag, j), $signed(out_data), exp_d[j]);
            check($sformatf("%s_last%0d", tag, j), out_last, (j == N-1) ? 1 : 0);
`ifdef FIR_SER_ROUND_SAT_EN
            check($sformatf("%s_sat%0d", tag, j), sat_flag, es[j]);
`endif
            step();
        end
        #1;
        check({tag, "_idle_valid"}, out_valid, 0);
        check({tag, "_idle_ready"}, in_ready, 1);
    endtask

    initial begin
        int st_rdy [6];
        int st_dat [6];
        int st_lst [6];
        int st_irdy[6];

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #12;
        check("rst_valid", out_valid, 0);
        check("rst_data", $signed(out_data), 0);
        check("rst_last", out_last, 0);
        check("rst_in_ready", in_ready, 1);
        step();
        reset = 1'b0;
        step();

        // Basic block: 3, -1, 0.
        run_block("basic", mk_blk(3 << 15, -(1 << 15), 0), 3, -1, 0, 3'b000);
        step();

        // Four back-to-back blocks, sample value equals its overall index.
        for (int c = 0; c <= 13; c++) begin
            int k;
            k = c / 3;
            in_valid  = (c < 12);
            in_data   = mk_blk((3*k) << 15, (3*k+1) << 15, (3*k+2) << 15);
            out_ready = 1'b1;
            #1;
            if (c < 12)
                check($sformatf("b2b_in_ready_c%0d", c), in_ready, (c % 3 == 0) ? 1 : 0);
            if (c >= 1 && c <= 12) begin
                check($sformatf("b2b_valid_c%0d", c), out_valid, 1);
                check($sformatf("b2b_data_c%0d", c), $signed(out_data), c - 1);
                check($sformatf("b2b_last_c%0d", c), out_last, (c % 3 == 0) ? 1 : 0);
            end
            if (c == 13)
                check("b2b_done_valid", out_valid, 0);
            step();
        end
        in_valid = 1'b0;

`ifdef FIR_SER_ROUND_SAT_EN
        run_block("round", mk_blk((5 << 15) + (1 << 14), -(1 << 14), 0), 6, 0, 0, 3'b000);
        run_block("sat", mk_blk(longint'(1) << 31, -(longint'(1) << 31), 0), 32767, -32768, 0, 3'b011);
`else
        run_block("round", mk_blk((5 << 15) + (1 << 14), -(1 << 14), 0), 5, -1, 0, 3'b000);
        run_block("sat", mk_blk(longint'(1) << 31, -(longint'(1) << 31), 0), 0, 0, 0, 3'b000);
`endif

        // Stall pattern with the next block already pending on in_valid.
        st_rdy  = '{1, 0, 0, 1, 0, 1};
        st_dat  = '{7, 8, 8, 8, 9, 9};
        st_lst  = '{0, 0, 0, 0, 1, 1};
        st_irdy = '{0, 0, 0, 0, 0, 1};
        in_valid  = 1'b1;
        in_data   = mk_blk(7 << 15, 8 << 15, 9 << 15);
        out_ready = 1'b1;
        step();
        in_data = mk_blk(1 << 15, 2 << 15, 3 << 15);
        for (int c = 0; c < 6; c++) begin
            out_ready = st_rdy[c][0];
            #1;
            check($sformatf("stall_data_c%0d", c), $signed(out_data), st_dat[c]);
            check($sformatf("stall_last_c%0d", c), out_last, st_lst[c]);
            check($sformatf("stall_in_ready_c%0d", c), in_ready, st_irdy[c]);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            #1;
            check($sformatf("stall_next_data%0d", j), $signed(out_data), j + 1);
            check($sformatf("stall_next_valid%0d", j), out_valid, 1);
            step();
        end
        #1;
        check("stall_end_valid", out_valid, 0);

        // Mid-block reset after the lane-0 handshake.
        in_valid  = 1'b1;
        in_data   = mk_blk(4 << 15, 5 << 15, 6 << 15);
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        #1;
        check("mrst_lane0", $signed(out_data), 4);
        step();
        #1;
        check("mrst_lane1_pre", $signed(out_data), 5);
        reset = 1'b1;
        #1;
        check("mrst_async_valid", out_valid, 0);
        check("mrst_async_data", $signed(out_data), 0);
        step();
        reset = 1'b0;
        #1;
        check("mrst_in_ready", in_ready, 1);
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("mrst_quiet_c%0d", c), out_valid, 0);
        end
        run_block("post_rst", mk_blk(-(2 << 15), 1 << 15, 0), -2, 1, 0, 3'b000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
